// File: rtl/scope_pkg.sv
// ----------------------------------------------------------------------------
// scope_pkg
// Shared definitions for the scope capture controller:
//   - state_t        : FSM encoding (IDLE=0, PREFILL=1, ARMED=2, POST=3, HOLD=4)
//   - *_DEF          : default sample width, address width and buffer depth
//   - wrap_inc       : circular-buffer address increment
//   - wrap_add       : circular-buffer address offset (operands already < depth)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package scope_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int ADDR_W_DEF = 11;
  localparam int DEPTH_DEF  = 800;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREFILL = 3'd1,
    ST_ARMED   = 3'd2,
    ST_POST    = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  // Next address in a buffer of 'depth' entries; depth-1 wraps to 0.
  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned depth);
    return (a == depth - 1) ? 0 : a + 1;
  endfunction

  // (a + off) mod depth, for a < depth and off < depth. A single conditional
  // subtract avoids a general modulo against a non-power-of-two depth.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned off,
                                           input int unsigned depth);
    int unsigned s;
    s = a + off;
    return (s >= depth) ? s - depth : s;
  endfunction

endpackage

// File: rtl/scope_trig_detect.sv
// ----------------------------------------------------------------------------
// scope_trig_detect
// Level/slope trigger with hysteresis. A trigger only fires after the signal
// has first been seen on the far side of the hysteresis band, which rejects
// noise hovering around the level.
// Ports:
//   clock, reset  in   clock / asynchronous active-high reset
//   clear         in   holds the hysteresis flag clear (controller not armed)
//   valid         in   sample is valid this cycle
//   sample        in   unsigned ADC sample
//   level         in   unsigned trigger threshold
//   slope         in   0 = rising, 1 = falling
//   hit           out  trigger condition met on this sample (combinational)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module scope_trig_detect #(
  parameter int DATA_W = 14,
  parameter int HYST   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] level,
  input  logic              slope,
  output logic              hit
);

  logic [DATA_W:0]   level_ext;
  logic [DATA_W:0]   lo_raw;
  logic [DATA_W:0]   hi_raw;
  logic [DATA_W-1:0] lo_sat;
  logic [DATA_W-1:0] hi_sat;
  logic              band_cond;
  logic              fire_cond;
  logic              flag;

  // Thresholds use one extra bit so under/overflow is visible, then clamp to
  // the sample range. With a clamped low threshold of 0, "sample < 0" can
  // never hold, so a rising trigger near zero stays disarmed.
  assign level_ext = {1'b0, level};
  assign lo_raw    = level_ext - (DATA_W+1)'(HYST);
  assign hi_raw    = level_ext + (DATA_W+1)'(HYST);
  assign lo_sat    = lo_raw[DATA_W] ? '0 : lo_raw[DATA_W-1:0];
  assign hi_sat    = hi_raw[DATA_W] ? '1 : hi_raw[DATA_W-1:0];

  assign band_cond = slope ? (sample > hi_sat) : (sample < lo_sat);
  assign fire_cond = slope ? (sample <= level) : (sample >= level);

  // The registered flag (from earlier samples) qualifies the fire compare.
  assign hit = valid && !clear && flag && fire_cond;

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values and simulation matches the hardware.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag <= 1'b0;
    end else if (clear) begin
      flag <= 1'b0;
    end else if (valid && band_cond) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/scope_capture_ctrl.sv
// ----------------------------------------------------------------------------
// scope_capture_ctrl
// Sequences triggered acquisition into the sample RAM used as a circular
// buffer: pre-trigger fill, armed trigger search, post-trigger fill, then hold
// until the display reader acknowledges the frame.
// Optional feature macro: SCOPE_AUTO_TRIG_EN (auto trigger after AUTO_TIMEOUT
// clocks in ARMED; otherwise ARMED waits indefinitely and auto_trig is 0).
// Ports:
//   clock, reset   in   clock / asynchronous active-high reset
//   sample_valid   in   sample_data valid this cycle
//   sample_data    in   ADC sample, unsigned
//   trig_level     in   trigger threshold (used live in ARMED)
//   trig_slope     in   0 = rising, 1 = falling (used live in ARMED)
//   single_mode    in   1: stop in IDLE after one frame
//   arm            in   pulse: start capture from IDLE
//   frame_ack      in   pulse: display finished with the held frame
//   wr_en/addr/data out registered RAM write port (1-cycle latency)
//   start_addr     out  oldest sample of the held frame
//   capture_done   out  high in HOLD
//   auto_trig      out  held frame was force-triggered
//   state          out  current FSM state
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int PRE_TRIG = 200,
  parameter int HYST     = 16
`ifdef SCOPE_AUTO_TRIG_EN
  ,
  parameter int AUTO_TIMEOUT = 1000000
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic              single_mode,
  input  logic              arm,
  input  logic              frame_ack,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] start_addr,
  output logic              capture_done,
  output logic              auto_trig,
  output logic [2:0]        state
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] ptr_q;      // address the next write will use
  logic [ADDR_W-1:0] cnt_q;      // writes in the current PREFILL / POST phase
  logic [ADDR_W-1:0] trig_addr;
  logic              write;
  logic              hit;
  logic              trig_event;
  logic              forced_hit;

  scope_trig_detect #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_trig (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != ST_ARMED),
    .valid  (sample_valid),
    .sample (sample_data),
    .level  (trig_level),
    .slope  (trig_slope),
    .hit    (hit)
  );

`ifdef SCOPE_AUTO_TRIG_EN
  logic [31:0] armed_cnt;

  // Saturates at the timeout; from then on the next valid sample is forced.
  assign forced_hit = (state_q == ST_ARMED) && sample_valid &&
                      (armed_cnt == 32'(AUTO_TIMEOUT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed_cnt <= '0;
      auto_trig <= 1'b0;
    end else begin
      if (state_q != ST_ARMED) begin
        armed_cnt <= '0;
      end else if (armed_cnt != 32'(AUTO_TIMEOUT)) begin
        armed_cnt <= armed_cnt + 32'd1;
      end
      // A genuine level hit takes precedence over the timeout.
      if (state_q == ST_ARMED && trig_event) begin
        auto_trig <= !hit;
      end
    end
  end
`else
  assign forced_hit = 1'b0;
  assign auto_trig  = 1'b0;
`endif

  assign trig_event   = hit || forced_hit;
  assign capture_done = (state_q == ST_HOLD);
  assign state        = state_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    write   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Continuous mode re-arms by itself; single mode waits for arm.
        if (arm || !single_mode) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        write = sample_valid;
        if (sample_valid && cnt_q == ADDR_W'(PRE_TRIG - 1)) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        write = sample_valid;
        if (trig_event) state_d = ST_POST;
      end
      ST_POST: begin
        write = sample_valid;
        if (sample_valid && cnt_q == ADDR_W'(DEPTH - PRE_TRIG - 1)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (frame_ack) state_d = single_mode ? ST_IDLE : ST_PREFILL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state_q <= state_d;
      wr_en   <= write;
      if (write) begin
        wr_addr <= ptr_q;
        wr_data <= sample_data;
        ptr_q   <= ADDR_W'(wrap_inc(32'(ptr_q), DEPTH));
      end

      // Phase counter restarts on every state change; the trigger sample is
      // already post sample 1.
      if (state_d != state_q) begin
        cnt_q <= (state_d == ST_POST) ? ADDR_W'(1) : '0;
      end else if (write) begin
        cnt_q <= cnt_q + ADDR_W'(1);
      end

      if (state_q == ST_ARMED && state_d == ST_POST) begin
        trig_addr <= ptr_q;
      end
      // Oldest sample sits just after the last post-trigger write.
      if (state_q == ST_POST && state_d == ST_HOLD) begin
        start_addr <= ADDR_W'(wrap_add(32'(trig_addr), DEPTH - PRE_TRIG, DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_scope_capture_ctrl
// Directed bench for scope_capture_ctrl with hand-computed expectations.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scope_capture_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [13:0] sample_data;
  logic [13:0] trig_level;
  logic        trig_slope;
  logic        single_mode;
  logic        arm;
  logic        frame_ack;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [13:0] wr_data;
  logic [10:0] start_addr;
  logic        capture_done;
  logic        auto_trig;
  logic [2:0]  state;

  int tests = 0;
  int fails = 0;
  int nwr;

  always #5 clock = ~clock;

`ifdef SCOPE_AUTO_TRIG_EN
  scope_capture_ctrl #(.AUTO_TIMEOUT(300)) dut (
`else
  scope_capture_ctrl dut (
`endif
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .single_mode  (single_mode),
    .arm          (arm),
    .frame_ack    (frame_ack),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start_addr   (start_addr),
    .capture_done (capture_done),
    .auto_trig    (auto_trig),
    .state        (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [13:0] v);
    sample_valid = 1'b1;
    sample_data  = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic pulse(input logic a, input logic f);
    arm       = a;
    frame_ack = f;
    tick();
    arm       = 1'b0;
    frame_ack = 1'b0;
  endtask

  initial begin
    logic [13:0] sat_vals [8];
    sat_vals = '{14'd0, 14'd10, 14'd0, 14'd20, 14'd4, 14'd5, 14'd3, 14'd16383};

    reset = 1'b1; sample_valid = 1'b0; sample_data = '0; trig_level = '0;
    trig_slope = 1'b0; single_mode = 1'b1; arm = 1'b0; frame_ack = 1'b0;
    repeat (2) tick();
    check("rst_state", state, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_start_addr", start_addr, 0);
    check("rst_done", capture_done, 0);
    check("rst_auto", auto_trig, 0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle_single_stays", state, 0);
    send(14'd123);
    check("idle_no_write", wr_en, 0);
    pulse(1'b0, 1'b1);
    check("idle_ack_ignored", state, 0);

    // Rising ramp, level 8000: flag sets on the wrap to 0 (index 256),
    // trigger at index 381 (value 8000); 381 + 600 = 981 writes in total.
    trig_level = 14'd8000; trig_slope = 1'b0;
    pulse(1'b1, 1'b0);
    check("arm_to_prefill", state, 1);
    nwr = 0;
    for (int i = 0; i <= 980; i++) begin
      send(14'(i * 64));
      if (wr_en) nwr++;
      if (i == 0)   check("first_wr_addr", wr_addr, 0);
      if (i == 198) check("prefill_199", state, 1);
      if (i == 199) check("prefill_done", state, 2);
      if (i == 300) begin
        pulse(1'b1, 1'b0);
        check("armed_arm_ignored", state, 2);
      end
      if (i == 380) check("no_trig_yet", state, 2);
      if (i == 381) begin
        check("trig_state", state, 3);
        check("trig_addr", wr_addr, 381);
        check("trig_data", wr_data, 8000);
      end
      if (i == 500) begin
        pulse(1'b0, 1'b1);
        check("post_ack_ignored", state, 3);
      end
      if (i == 979) check("post_not_done", state, 3);
    end
    check("total_writes", nwr, 981);
    check("hold_state", state, 4);
    check("hold_done", capture_done, 1);
    check("start_addr_1", start_addr, 181);
    check("auto_trig_0", auto_trig, 0);
    send(14'd5);
    check("hold_no_write", wr_en, 0);
    pulse(1'b1, 1'b0);
    check("hold_arm_ignored", state, 4);

    // Single mode: ack returns to IDLE and nothing is written.
    pulse(1'b0, 1'b1);
    check("single_to_idle", state, 0);
    check("idle_not_done", capture_done, 0);
    send(14'd7);
    check("idle_no_write2", wr_en, 0);
    single_mode = 1'b0;
    tick();
    check("cont_to_prefill", state, 1);

    // Falling, level 8000 (upper band 8016). Addresses continue from 181.
    trig_slope = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send(14'd8010);
      if (i == 0) check("wrap_continue", wr_addr, 181);
    end
    check("fall_armed", state, 2);
    send(14'd8010);
    check("fall_8010", state, 2);
    send(14'd7990);
    check("fall_7990_noflag", state, 2);
    send(14'd8020);
    check("fall_8020_flag", state, 2);
    send(14'd7995);
    check("fall_trig", state, 3);
    check("fall_trig_addr", wr_addr, 384);
    check("fall_trig_data", wr_data, 7995);
    for (int i = 0; i < 599; i++) send(14'd100);
    check("fall_hold", state, 4);
    check("start_addr_2", start_addr, 184);

    // arm and frame_ack together in HOLD: only the ack acts.
    pulse(1'b1, 1'b1);
    check("ack_arm_same", state, 1);

    // Saturated thresholds: rising level 5 and falling level 16380 never arm.
    trig_slope = 1'b0; trig_level = 14'd5;
    for (int i = 0; i < 200; i++) send(14'd100);
    check("sat_armed", state, 2);
    for (int i = 0; i < 8; i++) begin
      send(sat_vals[i]);
      check("sat_low_no_trig", state, 2);
    end
    trig_slope = 1'b1; trig_level = 14'd16380;
    send(14'd16383);
    check("sat_high_16383", state, 2);
    send(14'd0);
    check("sat_high_no_trig", state, 2);

    // Reach POST, then reset mid-frame.
    trig_slope = 1'b0; trig_level = 14'd100;
    send(14'd0);
    check("lvl100_flag", state, 2);
    send(14'd100);
    check("lvl100_trig", state, 3);
    check("lvl100_data", wr_data, 100);
    repeat (3) send(14'd50);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_wr_addr", wr_addr, 0);
    tick();
    check("mid_rst_state", state, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_done", capture_done, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    reset = 1'b0;
    tick();
    check("post_rst_prefill", state, 1);
    send(14'd9);
    check("post_rst_addr", wr_addr, 0);

`ifdef SCOPE_AUTO_TRIG_EN
    // Constant input below level: forced trigger when the ARMED clock count
    // reaches 300, i.e. on the 301st sample in ARMED.
    trig_level = 14'd8000;
    for (int i = 0; i < 199; i++) send(14'd1000);
    check("auto_armed", state, 2);
    nwr = 0;
    for (int i = 0; i < 400 && state != 3'd3; i++) begin
      send(14'd1000);
      nwr++;
    end
    check("auto_trig_state", state, 3);
    check("auto_trig_count", nwr, 301);
    for (int i = 0; i < 599; i++) send(14'd1000);
    check("auto_hold", capture_done, 1);
    check("auto_trig_flag", auto_trig, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
